// File: rtl/sa_os_ctrl_if.sv
// Control bundle between the systolic-array controller and its environment:
// tile request/abort, status, PE clear, operand feed and row-drain handshake.
interface sa_os_ctrl_if #(
  parameter int DIM = 16,
  parameter int KW  = 8
);
  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

  logic          START;
  logic [KW-1:0] K_LEN;
  logic          ABORT;
  logic          BUSY;
  logic          DONE;
  logic          ACC_CLR_N;
  logic          FEED_EN;
  logic [KW-1:0] FEED_IDX;
  logic          DRAIN_VALID;
  logic          DRAIN_READY;
  logic [RW-1:0] DRAIN_ROW;
  logic [15:0]   CYC_CNT;

  modport master (
    output START, K_LEN, ABORT, DRAIN_READY,
    input  BUSY, DONE, ACC_CLR_N, FEED_EN,
    input  FEED_IDX, DRAIN_VALID, DRAIN_ROW,
    input  CYC_CNT
  );

  modport slave (
    input  START, K_LEN, ABORT, DRAIN_READY,
    output BUSY, DONE, ACC_CLR_N, FEED_EN,
    output FEED_IDX, DRAIN_VALID, DRAIN_ROW,
    output CYC_CNT
  );
endinterface

// File: rtl/sa_os_ctrl.sv
// Output-stationary systolic array tile sequencer: CLEAR, FEED K operands,
// FLUSH the skew, DRAIN DIM rows, FIN. Ports: CLK, RST (async active-low),
// bus (sa_os_ctrl_if.slave). Optional cycle counter: SA_CTRL_PERF_EN.
module sa_os_ctrl #(
  parameter int DIM      = 16,
  parameter int KW       = 8,
  parameter int PIPE_LAT = 3
) (
  input logic        CLK,
  input logic        RST,
  sa_os_ctrl_if.slave bus
);
  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int F  = 2 * (DIM - 1) + PIPE_LAT;
  localparam int FW = (F > 1) ? $clog2(F) : 1;
  localparam logic [FW-1:0] F_LAST   = FW'(F - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED,
    S_FLUSH, S_DRAIN, S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] idx_q, idx_d;
  logic [FW-1:0] fl_q, fl_d;
  logic [RW-1:0] row_q, row_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          clr_n_q, clr_n_d;
  logic          feed_q, feed_d;
  logic          dval_q, dval_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    idx_d   = '0;
    fl_d    = '0;
    row_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          state_d = S_CLEAR;
          k_d     = bus.K_LEN;
        end
      end
      S_CLEAR: begin
        state_d = (k_q != '0) ? S_FEED : S_DRAIN;
      end
      S_FEED: begin
        if (idx_q == k_q - KW'(1)) state_d = S_FLUSH;
        else idx_d = idx_q + KW'(1);
      end
      S_FLUSH: begin
        if (fl_q == F_LAST) state_d = S_DRAIN;
        else fl_d = fl_q + FW'(1);
      end
      S_DRAIN: begin
        row_d = row_q;
        if (bus.DRAIN_READY) begin
          if (row_q == ROW_LAST) begin
            state_d = S_FIN;
            row_d   = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort beats every other transition, START included.
    if (bus.ABORT && state_q != S_IDLE) begin
      state_d = S_IDLE;
      idx_d   = '0;
      fl_d    = '0;
      row_d   = '0;
    end
    // Outputs are decoded from the next state so they are registered.
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    clr_n_d = (state_d != S_CLEAR);
    feed_d  = (state_d == S_FEED);
    dval_d  = (state_d == S_DRAIN);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      idx_q   <= '0;
      fl_q    <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_n_q <= 1'b0;
      feed_q  <= 1'b0;
      dval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      fl_q    <= fl_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_n_q <= clr_n_d;
      feed_q  <= feed_d;
      dval_q  <= dval_d;
    end
  end

`ifdef SA_CTRL_PERF_EN
  logic [15:0] cyc_q, cyc_d;

  // Zeroed on CLEAR entry; counts every busy cycle incl. CLEAR and FIN.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_IDLE && state_d == S_CLEAR)
      cyc_d = '0;
    else if (state_q != S_IDLE && cyc_q != 16'hFFFF)
      cyc_d = cyc_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cyc_q <= '0;
    else      cyc_q <= cyc_d;
  end

  assign bus.CYC_CNT = cyc_q;
`else
  assign bus.CYC_CNT = '0;
`endif

  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;
  assign bus.ACC_CLR_N   = clr_n_q;
  assign bus.FEED_EN     = feed_q;
  assign bus.FEED_IDX    = idx_q;
  assign bus.DRAIN_VALID = dval_q;
  assign bus.DRAIN_ROW   = row_q;
endmodule

// File: tb/tb_sa_os_ctrl.sv
// Scoreboard bench for sa_os_ctrl: expected clear/feed/drain/done events
// are queued at tile start and popped by a negedge monitor.
module tb_sa_os_ctrl;
  localparam int DIM = 16;
  localparam int KW  = 8;
  localparam int PL  = 3;
  localparam int F   = 2 * (DIM - 1) + PL;
`ifdef SA_CTRL_PERF_EN
  localparam int EXP_CYC = 55;
`else
  localparam int EXP_CYC = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sa_os_ctrl_if #(.DIM(DIM), .KW(KW)) bus ();

  sa_os_ctrl #(
    .DIM(DIM), .KW(KW), .PIPE_LAT(PL)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t q_clr[$];
  ev_t q_feed[$];
  ev_t q_drain[$];
  ev_t q_done[$];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;
  int t0 = 0;
  int stall_rel = 0;
  int stall_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  task automatic flush_q();
    q_clr.delete();
    q_feed.delete();
    q_drain.delete();
    q_done.delete();
  endtask

  task automatic chk_rst_vals(string p);
    chk({p, "_busy"}, int'(bus.BUSY), 0);
    chk({p, "_done"}, int'(bus.DONE), 0);
    chk({p, "_clr_n"}, int'(bus.ACC_CLR_N), 0);
    chk({p, "_feed_en"}, int'(bus.FEED_EN), 0);
    chk({p, "_feed_idx"}, int'(bus.FEED_IDX), 0);
    chk({p, "_dvalid"}, int'(bus.DRAIN_VALID), 0);
    chk({p, "_drow"}, int'(bus.DRAIN_ROW), 0);
    chk({p, "_cyc_cnt"}, int'(bus.CYC_CNT), 0);
  endtask

  // Event times are absolute cyc values: relative cycle rel maps to t+rel-1.
  task automatic push_tile(int k, int t, int srow, int slen);
    int base;
    ev_t e;
    e.cyc = t;
    e.val = 0;
    q_clr.push_back(e);
    for (int i = 0; i < k; i++) begin
      e.cyc = t + 1 + i;
      e.val = i;
      q_feed.push_back(e);
    end
    base = (k != 0) ? 2 + k + F : 2;
    for (int r = 0; r < DIM; r++) begin
      e.cyc = t + base + r - 1 + ((r >= srow) ? slen : 0);
      e.val = r;
      q_drain.push_back(e);
    end
    e.cyc = t + base + DIM + slen - 1;
    e.val = 1;
    q_done.push_back(e);
    stall_rel = base + srow;
    stall_len = slen;
  endtask

  task automatic start_tile(int k);
    bus.START = 1'b1;
    bus.K_LEN = KW'(k);
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.START = 1'b0;
    bus.DRAIN_READY = 1'b1;
  endtask

  task automatic wait_done(int budget);
    int rel;
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      rel = cyc - t0 + 1;
      bus.DRAIN_READY = !(stall_len > 0 && rel >= stall_rel &&
                          rel < stall_rel + stall_len);
      if (q_done.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_in_time", int'(ok), 1);
    chk("clr_q_left", q_clr.size(), 0);
    chk("feed_q_left", q_feed.size(), 0);
    chk("drain_q_left", q_drain.size(), 0);
    if (!ok) flush_q();
    bus.DRAIN_READY = 1'b1;
    stall_len = 0;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (!bus.ACC_CLR_N) begin
        if (q_clr.size() == 0) chk("clr_unexp", cyc, -1);
        else begin
          e = q_clr.pop_front();
          chk("clr_cyc", cyc, e.cyc);
        end
      end
      if (bus.FEED_EN) begin
        if (q_feed.size() == 0) chk("feed_unexp", cyc, -1);
        else begin
          e = q_feed.pop_front();
          chk("feed_cyc", cyc, e.cyc);
          chk("feed_idx", int'(bus.FEED_IDX), e.val);
        end
      end
      if (bus.DRAIN_VALID && bus.DRAIN_READY) begin
        if (q_drain.size() == 0) chk("drain_unexp", cyc, -1);
        else begin
          e = q_drain.pop_front();
          chk("drain_cyc", cyc, e.cyc);
          chk("drain_row", int'(bus.DRAIN_ROW), e.val);
        end
      end
      if (bus.DONE) begin
        if (q_done.size() == 0) chk("done_unexp", cyc, -1);
        else begin
          e = q_done.pop_front();
          chk("done_cyc", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    bus.START = 1'b0;
    bus.K_LEN = '0;
    bus.ABORT = 1'b0;
    bus.DRAIN_READY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_rst_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_n_rise", int'(bus.ACC_CLR_N), 1);
    mon_en = 1'b1;

    start_tile(4);
    push_tile(4, t0, DIM, 0);
    wait_done(200);
    chk("cyc_cnt_k4", int'(bus.CYC_CNT), EXP_CYC);

    start_tile(0);
    push_tile(0, t0, DIM, 0);
    wait_done(100);

    start_tile(4);
    push_tile(4, t0, 7, 5);
    wait_done(200);

    // Abort with START in a FLUSH cycle, restart one cycle later.
    start_tile(4);
    push_tile(4, t0, DIM, 0);
    q_drain.delete();
    q_done.delete();
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("flush_busy", int'(bus.BUSY), 1);
    chk("flush_feed_en", int'(bus.FEED_EN), 0);
    bus.ABORT = 1'b1;
    bus.START = 1'b1;
    bus.K_LEN = 8'd2;
    @(posedge clk);
    #1;
    chk("abort_busy", int'(bus.BUSY), 0);
    chk("abort_feed_en", int'(bus.FEED_EN), 0);
    chk("abort_dvalid", int'(bus.DRAIN_VALID), 0);
    chk("abort_done", int'(bus.DONE), 0);
    chk("abort_feed_q", q_feed.size(), 0);
    bus.ABORT = 1'b0;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus.START = 1'b0;
    push_tile(2, t0, DIM, 0);
    chk("restart_busy", int'(bus.BUSY), 1);
    wait_done(200);

    // Asynchronous reset in the middle of FEED.
    start_tile(8);
    push_tile(8, t0, DIM, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_feed_en", int'(bus.FEED_EN), 1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_rst_vals("midrst");
    flush_q();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_clr_n_rise", int'(bus.ACC_CLR_N), 1);
    chk("midrst_busy", int'(bus.BUSY), 0);
    mon_en = 1'b1;

    for (int n = 0; n < 2; n++) begin
      k = $urandom_range(1, 20);
      start_tile(k);
      push_tile(k, t0, DIM, 0);
      wait_done(300);
    end

    // ABORT in IDLE must not block START.
    bus.ABORT = 1'b1;
    start_tile(3);
    bus.ABORT = 1'b0;
    push_tile(3, t0, DIM, 0);
    wait_done(200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sa_os_ctrl.md
SA_OS_CTRL -- requirements
Module: sa_os_ctrl

Interface
REQ-001 Parameter DIM, default 16: PE array rows/columns (square output-stationary array).
REQ-002 Parameter KW, default 8: width of reduction-length and feed-index fields.
REQ-003 Parameter PIPE_LAT, default 3: PE operand-to-accumulator latency in cycles (multiplier plus product register).
REQ-004 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 START  in  1  request one tile computation; sampled only in IDLE.
REQ-007 K_LEN  in  KW  operand pairs per tile; captured in the same cycle START is accepted.
REQ-008 ABORT  in  1  synchronous cancel of the current tile.
REQ-009 BUSY  out  1  high in every state except IDLE.
REQ-010 DONE  out  1  one-cycle pulse on tile completion.
REQ-011 ACC_CLR_N  out  1  active-low clear to the PE accumulators.
REQ-012 FEED_EN  out  1  operand sources present operand index FEED_IDX to row/column 0 this cycle.
REQ-013 FEED_IDX  out  KW  current operand index, 0..K_LEN-1.
REQ-014 DRAIN_VALID  out  1  accumulator row DRAIN_ROW is ready for readout.
REQ-015 DRAIN_READY  in  1  consumer accepts the row; transfer occurs when DRAIN_VALID and DRAIN_READY are both high.
REQ-016 DRAIN_ROW  out  clog2(DIM)  row index under readout.
REQ-017 CYC_CNT  out  16  tile cycle count (see Configuration).

Function
REQ-018 FSM states: IDLE, CLEAR, FEED, FLUSH, DRAIN, FIN; all outputs are registered.
REQ-019 IDLE: START=1 latches K_LEN and moves to CLEAR; START while not in IDLE is ignored.
REQ-020 CLEAR: lasts 1 cycle with ACC_CLR_N=0; moves to FEED if the latched K_LEN is nonzero, otherwise to DRAIN.
REQ-021 FEED: lasts exactly K_LEN cycles with FEED_EN=1; FEED_IDX starts at 0 and increments by 1 per cycle; moves to FLUSH after index K_LEN-1.
REQ-022 FLUSH: lasts exactly F = 2*(DIM-1)+PIPE_LAT cycles with FEED_EN=0, so that skewed operands reach PE(DIM-1,DIM-1) and its accumulator settles; then moves to DRAIN.
REQ-023 DRAIN: DRAIN_VALID=1 and DRAIN_ROW starts at 0; DRAIN_ROW increments on each transfer.
REQ-024 DRAIN exit: the transfer with DRAIN_ROW=DIM-1 moves the FSM to FIN; DRAIN_VALID and DRAIN_ROW hold while DRAIN_READY=0.
REQ-025 FIN: lasts 1 cycle with DONE=1, then returns to IDLE.
REQ-026 Timing: START accepted at edge t gives CLEAR in cycle t+1, FEED in cycles t+2..t+1+K, and first DRAIN_VALID in cycle t+2+K+F.
REQ-027 ABORT=1 in any non-IDLE state returns the FSM to IDLE on the next edge with FEED_EN=0, DRAIN_VALID=0 and no DONE pulse.
REQ-028 ABORT has priority over every other transition, including START in the same cycle; ABORT in IDLE has no effect.
REQ-029 Outside CLEAR, ACC_CLR_N=1; outside FEED, FEED_EN=0 and FEED_IDX=0; outside DRAIN, DRAIN_VALID=0 and DRAIN_ROW=0.

Reset
REQ-030 While RST=0: state=IDLE, BUSY=0, DONE=0, FEED_EN=0, FEED_IDX=0, DRAIN_VALID=0, DRAIN_ROW=0, CYC_CNT=0, latched K_LEN=0, internal counters=0, ACC_CLR_N=0.
REQ-031 ACC_CLR_N rises to 1 on the first CLK edge after RST deasserts.
REQ-032 RST asserted mid-tile aborts the tile immediately and does not generate a DONE pulse.

Configuration
REQ-033 With macro SA_CTRL_PERF_EN defined: CYC_CNT clears when CLEAR is entered, increments each cycle while BUSY, saturates at 16'hFFFF, and holds its value in IDLE.
REQ-034 Without SA_CTRL_PERF_EN: the CYC_CNT port remains and is constant 0, and no counter logic is built.

Verification (DIM=16, PIPE_LAT=3, so F=33)
REQ-035 START at t=0, K_LEN=4, DRAIN_READY=1 -> ACC_CLR_N=0 at cycle 1; FEED_EN at cycles 2-5 with FEED_IDX 0,1,2,3; DRAIN_VALID at cycles 39-54 with rows 0-15; DONE at cycle 55.
REQ-036 K_LEN=0 -> CLEAR at cycle 1; DRAIN starts at cycle 2 with no FEED_EN and no FLUSH; DONE at cycle 18.
REQ-037 K_LEN=4 with DRAIN_READY held 0 for 5 cycles at row 7 -> DRAIN_ROW holds 7 and DONE is delayed by exactly 5 cycles (cycle 60).
REQ-038 ABORT in a FLUSH cycle, together with START -> IDLE next cycle, no DONE; START is then accepted one cycle later.
REQ-039 RST pulsed low during FEED -> all outputs take their REQ-030 values asynchronously; ACC_CLR_N=1 after the first edge following release.
REQ-040 SA_CTRL_PERF_EN defined, K_LEN=4, DRAIN_READY=1 -> CYC_CNT=55 after DONE; the same scenario with the macro undefined -> CYC_CNT=0.
